fp_align_sequencer: RTL and testbench
=====================================

FP_ALIGN_SEQUENCER -- requirements
Module: fp_align_sequencer

Interface
REQ-001 SHALL have no parameters; all widths are fixed for IEEE-754 single precision.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Port clk: input, 1 bit, rising-edge clock.
REQ-004 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-005 Port in_valid: input, 1 bit, operand pair offered.
REQ-006 Port in_ready: output, 1 bit, block can accept operands.
REQ-007 Port a: input, 32 bits, operand A (float32).
REQ-008 Port b: input, 32 bits, operand B (float32).
REQ-009 Port out_valid: output, 1 bit, aligned result available.
REQ-010 Port out_ready: input, 1 bit, consumer accepts result.
REQ-011 Port exp_out: output, 8 bits, common (larger) exponent.
REQ-012 Port mant_big: output, 24 bits, {hidden, fraction} of the larger-exponent operand.
REQ-013 Port mant_small: output, 27 bits, aligned {hidden, fraction, guard, round, sticky} of the other operand.
REQ-014 Port sign_big: output, 1 bit, sign of the larger-exponent operand.
REQ-015 Port sign_small: output, 1 bit, sign of the smaller-exponent operand.
REQ-016 Port swapped: output, 1 bit, set when B has the larger exponent.
REQ-017 Port eff_sub: output, 1 bit, equals sign_a XOR sign_b.
REQ-018 Port busy: output, 1 bit, high in any state other than IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, COMPARE, SHIFT, DONE.
REQ-020 in_ready SHALL be 1 only in IDLE.
REQ-021 In IDLE, in_valid=1 SHALL capture a and b and move the FSM to COMPARE.
REQ-022 Exponent field 0 SHALL use hidden bit 0 and effective exponent 1; any other exponent SHALL use hidden bit 1 and the raw exponent.
REQ-023 The exponent difference SHALL be computed in COMPARE by one adder_subtractor_8bit instance (A=eff_exp_a, B=eff_exp_b, Ctl=1, enable=1).
REQ-024 Swap rule: Cout=1 (ea>=eb) SHALL give swapped=0; Cout=0 SHALL give swapped=1, so equal exponents never swap.
REQ-025 The shift magnitude SHALL be the Difference output of the subtractor instance.
REQ-026 The shift count SHALL be loaded as min(magnitude, 26).
REQ-027 The 26-bit small-mantissa register SHALL be loaded with {hidden, fraction, 2'b00}, and sticky SHALL be cleared.
REQ-028 COMPARE SHALL last one cycle, going to DONE if the count is 0 and to SHIFT otherwise.
REQ-029 Each SHIFT cycle SHALL shift the register right by 1, OR the bit shifted out into sticky, and decrement the count.
REQ-030 SHIFT SHALL go to DONE on the cycle in which the count reaches 0.
REQ-031 mant_small SHALL equal {register, sticky}.
REQ-032 With magnitude 26 or more, all set bits SHALL end up in sticky.
REQ-033 out_valid SHALL rise N+2 clock edges after the accepting edge, where N is the shift count.
REQ-034 In DONE, out_valid SHALL be 1 and all result outputs SHALL stay stable until out_ready=1.
REQ-035 DONE with out_ready=1 SHALL return the FSM to IDLE on the next edge; a new input SHALL NOT be accepted in that same cycle.
REQ-036 While out_valid=0, result outputs SHALL hold their last values.
REQ-037 in_valid and operand changes outside IDLE SHALL be ignored.

Reset
REQ-038 rst_n=0 SHALL, asynchronously, force IDLE and clear out_valid, busy, every result output and the internal registers.
REQ-039 After reset release, in_ready SHALL be 1.
REQ-040 Reset asserted mid-SHIFT or mid-DONE SHALL discard the operation, with no out_valid pulse afterwards.

Verification
REQ-041 a=0x40400000, b=0x3F800000 -> swapped=0, exp_out=0x80, mant_big=0xC00000, mant_small=0x2000000, out_valid 3 edges after accept.
REQ-042 a=0x3F800000, b=0xC0400000 -> swapped=1, exp_out=0x80, mant_big=0xC00000, sign_big=1, eff_sub=1.
REQ-043 a=b=0x3F800000 -> swapped=0, mant_small=0x4000000, out_valid 2 edges after accept.
REQ-044 a=0x7F000000, b=0x3F800000 (difference 127) -> 26 shifts, mant_small=0x0000001, out_valid 28 edges after accept.
REQ-045 out_ready held 0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE next edge, then in_ready=1.
REQ-046 rst_n pulsed low during SHIFT -> immediate out_valid=0 and busy=0, in_ready=1 after release, and the next transaction is correct.

Source files
------------

// File: rtl/fp_align_sequencer.sv
// fp_align_sequencer: multi-cycle float32 operand alignment for an adder.
// Captures an operand pair and picks the larger-exponent operand. It then
// right-shifts the other mantissa one bit per cycle into a guard/round/sticky
// extended field.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     operand handshake (ready only in IDLE)
//   a, b                    float32 operands
//   out_valid / out_ready   result handshake (result held until accepted)
//   exp_out                 common (larger effective) exponent
//   mant_big                {hidden, fraction} of the larger-exponent operand
//   mant_small              aligned {hidden, fraction, guard, round, sticky}
//   sign_big, sign_small    signs of the larger / smaller exponent operands
//   swapped                 B had the strictly larger exponent
//   eff_sub                 sign_a ^ sign_b
//   busy                    FSM not in IDLE

// 8-bit adder/subtractor. Ctl=1 subtracts (A-B). Cout=1 means A>=B when
// subtracting. Difference is the magnitude |A-B| when subtracting and A+B
// otherwise. Outputs are zero when disabled.
module adder_subtractor_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Ctl,
  input  logic       enable,
  output logic [7:0] Difference,
  output logic       Cout
);
  logic [8:0] raw;

  always_comb begin
    raw        = {1'b0, A} + {1'b0, (Ctl ? ~B : B)} + {8'd0, Ctl};
    Difference = '0;
    Cout       = 1'b0;
    if (enable) begin
      Cout       = raw[8];
      Difference = (Ctl && !raw[8]) ? (~raw[7:0] + 8'd1) : raw[7:0];
    end
  end
endmodule

module fp_align_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  exp_out,
  output logic [23:0] mant_big,
  output logic [26:0] mant_small,
  output logic        sign_big,
  output logic        sign_small,
  output logic        swapped,
  output logic        eff_sub,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, COMPARE, SHIFT, DONE} state_t;

  state_t      state;
  logic [31:0] op_a, op_b;
  logic [25:0] sreg;
  logic        sticky;
  logic [4:0]  cnt;
  logic [7:0]  pend_exp;
  logic [23:0] pend_mbig;
  logic        pend_sbig, pend_ssmall, pend_swap;

  logic        hid_a, hid_b, ge, swap_c;
  logic [7:0]  eexp_a, eexp_b, mag;
  logic [4:0]  cnt_init;
  logic [25:0] small_init, sreg_sh;
  logic        sticky_sh;
  logic [7:0]  fin_exp;
  logic [23:0] fin_mbig;
  logic        fin_sbig, fin_ssmall, fin_swap;

  // Denormals (exponent field 0) use hidden bit 0 and effective exponent 1.
  assign hid_a  = |op_a[30:23];
  assign hid_b  = |op_b[30:23];
  assign eexp_a = hid_a ? op_a[30:23] : 8'd1;
  assign eexp_b = hid_b ? op_b[30:23] : 8'd1;

  adder_subtractor_8bit u_expdiff (
    .A          (eexp_a),
    .B          (eexp_b),
    .Ctl        (1'b1),
    .enable     (1'b1),
    .Difference (mag),
    .Cout       (ge)
  );

  always_comb begin
    swap_c     = ~ge;
    cnt_init   = (mag > 8'd26) ? 5'd26 : mag[4:0];
    small_init = swap_c ? {hid_a, op_a[22:0], 2'b00} : {hid_b, op_b[22:0], 2'b00};
    sreg_sh    = {1'b0, sreg[25:1]};
    sticky_sh  = sticky | sreg[0];
    // Result fields come straight from the comparison on a zero-shift
    // completion, otherwise from the values parked at COMPARE.
    if (state == COMPARE) begin
      fin_exp    = swap_c ? eexp_b : eexp_a;
      fin_mbig   = swap_c ? {hid_b, op_b[22:0]} : {hid_a, op_a[22:0]};
      fin_sbig   = swap_c ? op_b[31] : op_a[31];
      fin_ssmall = swap_c ? op_a[31] : op_b[31];
      fin_swap   = swap_c;
    end else begin
      fin_exp    = pend_exp;
      fin_mbig   = pend_mbig;
      fin_sbig   = pend_sbig;
      fin_ssmall = pend_ssmall;
      fin_swap   = pend_swap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      sreg        <= '0;
      sticky      <= 1'b0;
      cnt         <= '0;
      pend_exp    <= '0;
      pend_mbig   <= '0;
      pend_sbig   <= 1'b0;
      pend_ssmall <= 1'b0;
      pend_swap   <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      exp_out     <= '0;
      mant_big    <= '0;
      mant_small  <= '0;
      sign_big    <= 1'b0;
      sign_small  <= 1'b0;
      swapped     <= 1'b0;
      eff_sub     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a     <= a;
            op_b     <= b;
            state    <= COMPARE;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        COMPARE: begin
          sreg        <= small_init;
          sticky      <= 1'b0;
          cnt         <= cnt_init;
          pend_exp    <= fin_exp;
          pend_mbig   <= fin_mbig;
          pend_sbig   <= fin_sbig;
          pend_ssmall <= fin_ssmall;
          pend_swap   <= fin_swap;
          if (cnt_init == 5'd0) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            exp_out    <= fin_exp;
            mant_big   <= fin_mbig;
            mant_small <= {small_init, 1'b0};
            sign_big   <= fin_sbig;
            sign_small <= fin_ssmall;
            swapped    <= fin_swap;
            eff_sub    <= op_a[31] ^ op_b[31];
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sreg   <= sreg_sh;
          sticky <= sticky_sh;
          cnt    <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            exp_out    <= fin_exp;
            mant_big   <= fin_mbig;
            mant_small <= {sreg_sh, sticky_sh};
            sign_big   <= fin_sbig;
            sign_small <= fin_ssmall;
            swapped    <= fin_swap;
            eff_sub    <= op_a[31] ^ op_b[31];
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_align_sequencer.sv
// Randomized self-checking bench for fp_align_sequencer against an
// arithmetic reference model of the alignment rules.
module tb_fp_align_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0, b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  exp_out;
  logic [23:0] mant_big;
  logic [26:0] mant_small;
  logic        sign_big, sign_small, swapped, eff_sub, busy;

  int n_tests = 0;
  int n_fail  = 0;

  fp_align_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .exp_out    (exp_out),
    .mant_big   (mant_big),
    .mant_small (mant_small),
    .sign_big   (sign_big),
    .sign_small (sign_small),
    .swapped    (swapped),
    .eff_sub    (eff_sub),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned exp;
    int unsigned mbig;
    int unsigned msmall;
    int unsigned sbig;
    int unsigned ssmall;
    int unsigned swp;
    int unsigned esub;
    int unsigned n;
  } res_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
    res_t r;
    int unsigned fx, fy, ex, ey, mx, my, ms, d;
    longint unsigned wide, keep;
    logic st;
    fx = int'(x[30:23]);
    fy = int'(y[30:23]);
    ex = (fx == 0) ? 1 : fx;
    ey = (fy == 0) ? 1 : fy;
    mx = int'(x[22:0]) + ((fx == 0) ? 0 : (1 << 23));
    my = int'(y[22:0]) + ((fy == 0) ? 0 : (1 << 23));
    r.swp  = (ey > ex) ? 1 : 0;
    r.esub = (x[31] != y[31]) ? 1 : 0;
    if (r.swp == 1) begin
      r.exp = ey; r.mbig = my; ms = mx; d = ey - ex;
      r.sbig = y[31]; r.ssmall = x[31];
    end else begin
      r.exp = ex; r.mbig = mx; ms = my; d = ex - ey;
      r.sbig = x[31]; r.ssmall = y[31];
    end
    wide = longint'(ms) * 4;
    if (d >= 26) begin
      keep = 0;
      st = (ms != 0);
    end else begin
      keep = wide >> d;
      st = (wide % (64'd1 << d)) != 0;
    end
    r.msmall = int'(keep) * 2 + (st ? 1 : 0);
    r.n = (d > 26) ? 26 : d;
    return r;
  endfunction

  task automatic check_result(input string pfx, input res_t r);
    check({pfx, "_exp"},    32'(exp_out),    32'(r.exp));
    check({pfx, "_mbig"},   32'(mant_big),   32'(r.mbig));
    check({pfx, "_msmall"}, 32'(mant_small), 32'(r.msmall));
    check({pfx, "_sbig"},   32'(sign_big),   32'(r.sbig));
    check({pfx, "_ssmall"}, 32'(sign_small), 32'(r.ssmall));
    check({pfx, "_swap"},   32'(swapped),    32'(r.swp));
    check({pfx, "_esub"},   32'(eff_sub),    32'(r.esub));
  endtask

  // One complete transaction: accept, latency, result, hold, release.
  task automatic run_txn(input logic [31:0] x, input logic [31:0] y, input int hold);
    res_t r;
    int   lat;
    int   waited;
    r = model(x, y);
    waited = 0;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    check("ready_wait", 32'(waited < 50), 32'd1);
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    check("acc_busy", 32'(busy), 32'd1);
    check("acc_inrdy", 32'(in_ready), 32'd0);
    // Operand churn and in_valid outside IDLE must be ignored.
    a = $urandom; b = $urandom;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
      a = $urandom; b = $urandom;
    end
    check("latency", 32'(lat), 32'(r.n + 2));
    check_result("res", r);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_ov", 32'(out_valid), 32'd1);
      check("hold_inrdy", 32'(in_ready), 32'd0);
      check_result("hold", r);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("rel_ov", 32'(out_valid), 32'd0);
    check("rel_inrdy", 32'(in_ready), 32'd1);
    check("rel_busy", 32'(busy), 32'd0);
    out_ready = 1'b0; in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_pair_b(input logic [31:0] x);
    int unsigned e;
    int          ee;
    logic [7:0]  ef;
    e = $urandom_range(0, 3);
    if (e == 0) begin
      ef = 8'($urandom);
    end else if (e == 1) begin
      ef = 8'd0;
    end else begin
      ee = int'(x[30:23]) + int'($urandom_range(0, 60)) - 30;
      if (ee < 0) ee = 0;
      if (ee > 255) ee = 255;
      ef = 8'(ee);
    end
    return {1'($urandom), ef, 23'($urandom)};
  endfunction

  initial begin
    logic [31:0] x;
    int          pulses;
    #2;
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_exp", 32'(exp_out), 32'd0);
    check("rst_msmall", 32'(mant_small), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("rst_inrdy", 32'(in_ready), 32'd1);

    run_txn(32'h40400000, 32'h3F800000, 1);
    check("d41_msmall", 32'(mant_small), 32'h2000000);
    run_txn(32'h3F800000, 32'hC0400000, 0);
    run_txn(32'h3F800000, 32'h3F800000, 0);
    run_txn(32'h7F000000, 32'h3F800000, 2);
    run_txn(32'h40400000, 32'h00000001, 5);

    for (int t = 0; t < 40; t++) begin
      x = $urandom;
      if (($urandom % 4) == 0) x[30:23] = 8'd0;
      run_txn(x, rand_pair_b(x), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a long shift.
    @(posedge clk); #1;
    a = 32'h4B000000; b = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ov", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("post_rst_inrdy", 32'(in_ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) pulses++;
    end
    check("post_rst_nopulse", 32'(pulses), 32'd0);
    run_txn(32'h40400000, 32'h3F800000, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
